gpio_in_debounce: RTL

Input conditioning stage between the 8 GPIO pads and the GPIO register block's data-capture path. Per pin, it synchronises the asynchronous pad level, filters glitches with a programmable debounce counter, and produces a clean level plus single-cycle rise/fall pulses. The register block samples pin_o instead of raw pads. Its interrupt-pending logic may consume rise_o/fall_o.

---
 rtl/gpio_in_debounce.sv | 74 +++++++
 1 files changed

// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - per-pin pad synchroniser, debounce filter and edge pulse generator
// Each lane is independent: a pad level must hold against the stable level for L+1 cycles to be accepted.
module gpio_in_debounce #(
   parameter int NUM_PINS    = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PINS-1:0]  pad_i,
   input  logic [NUM_PINS-1:0]  deb_en_i,
   input  logic [DEB_CNT_W-1:0] deb_limit_i,
   output logic [NUM_PINS-1:0]  pin_o,
   output logic [NUM_PINS-1:0]  rise_o,
   output logic [NUM_PINS-1:0]  fall_o
);

   localparam logic [DEB_CNT_W-1:0] CNT_ONE = {{(DEB_CNT_W-1){1'b0}}, 1'b1};

   logic [NUM_PINS-1:0]  sync_q [SYNC_STAGES];
   logic [NUM_PINS-1:0]  sync;
   logic [NUM_PINS-1:0]  stable_q;
   logic [NUM_PINS-1:0]  rise_q;
   logic [NUM_PINS-1:0]  fall_q;
   logic [DEB_CNT_W-1:0] cnt_q [NUM_PINS];

   // Plain flop chain: no logic between stages so metastability has full cycles to settle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= pad_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // The >= compare lets a lowered limit release a count already past it on the next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         for (int i = 0; i < NUM_PINS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PINS; i++) begin
            rise_q[i] <= 1'b0;
            fall_q[i] <= 1'b0;
            if (sync[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (!deb_en_i[i] || (cnt_q[i] >= deb_limit_i)) begin
               stable_q[i] <= sync[i];
               cnt_q[i]    <= '0;
               rise_q[i]   <= sync[i];
               fall_q[i]   <= ~sync[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   assign pin_o  = stable_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule
